// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit serialiser.
//  - Field positions of the 9-bit character bus {valid, data[7:0]}.
//  - Transmit FSM state encoding.
package uart_tx_serializer_pkg;

    localparam int unsigned UART_VALID_BIT = 8;
    localparam int unsigned UART_DATA_W    = 8;

    // Index of the last data bit within a frame (8 data bits, 0..7).
    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering characters ahead of the serialiser.
// Ports:
//  clock  in   system clock, rising edge
//  reset  in   asynchronous active-high reset; empties the FIFO
//  push   in   write wdata this cycle (ignored when full unless popping too)
//  pop    in   drop the head entry this cycle (ignored when empty)
//  wdata  in   data to write
//  rdata  out  head entry (valid while not empty)
//  count  out  occupancy 0..2**AW
//  full   out  count == 2**AW
//  empty  out  count == 0
module uart_tx_fifo
    import uart_tx_serializer_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned AW     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

    logic [DATA_W-1:0] mem_q [2**AW];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == Depth);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push while full is only taken when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are never read once the pointers clear.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffers strobed characters from the 9-bit UART bus and serialises them as 8N1
// frames (idle high, start 0, 8 data bits LSB first, stop 1).
// Ports:
//  clock         in   system clock, rising edge
//  reset         in   asynchronous active-high reset; aborts any frame
//  char_in       in   [8] one-cycle valid strobe, [7:0] character
//  tx            out  registered serial line
//  busy          out  frame on the line or characters buffered
//  fifo_count    out  FIFO occupancy 0..2**FIFO_AW
//  overflow      out  sticky: strobe seen while FIFO full
//  overflow_clr  in   synchronous clear of overflow (set wins)
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [UART_VALID_BIT:0]   char_in,
    output logic                      tx,
    output logic                      busy,
    output logic [FIFO_AW:0]          fifo_count,
    output logic                      overflow,
    input  logic                      overflow_clr
);

    localparam int unsigned    BaudW    = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    tx_state_e              state_q, state_d;
    logic [BaudW-1:0]       baud_q, baud_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   overflow_q, overflow_d;

    logic                   strobe;
    logic                   pop;
    logic                   baud_end;
    logic [UART_DATA_W-1:0] fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign strobe   = char_in[UART_VALID_BIT];
    assign baud_end = (baud_q == BaudLast);

    uart_tx_fifo #(
        .DATA_W (UART_DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (strobe),
        .pop   (pop),
        .wdata (char_in[UART_DATA_W-1:0]),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the pop happens on the transition into StStart.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_end && (bit_idx_q == LAST_DATA_BIT)) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (baud_end) begin
                    // Chain straight into the next frame when one is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic. tx is registered from the current state, so the line lags
    // the FSM by one cycle uniformly and frames stay contiguous.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StIdle:  tx_d = 1'b1;
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            StStop:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Baud counter, bit index, shift register and overflow next-state.
    always_comb begin
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;

        if (state_q == StIdle || baud_end) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BaudW'(1);
        end

        if (state_q != StData) begin
            bit_idx_d = '0;
        end else if (baud_end) begin
            bit_idx_d = bit_idx_q + 3'd1;
        end

        if (pop) begin
            shift_d = fifo_rdata;
        end else if (state_q == StData && baud_end) begin
            shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
        end

        if (strobe && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle) | (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    logic       clock = 1'b0;
    logic       reset;
    logic [8:0] char_in;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       overflow_clr;

    // Second instance with the minimum bit period for the streaming test.
    logic [8:0] char_in2;
    logic       tx2;
    logic       busy2;
    logic [4:0] fifo_count2;
    logic       overflow2;
    logic       overflow_clr2;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_tx_serializer #(
        .CLKS_PER_BIT (16),
        .FIFO_AW      (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .char_in      (char_in),
        .tx           (tx),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    uart_tx_serializer #(
        .CLKS_PER_BIT (2),
        .FIFO_AW      (4)
    ) dut2 (
        .clock        (clock),
        .reset        (reset),
        .char_in      (char_in2),
        .tx           (tx2),
        .busy         (busy2),
        .fifo_count   (fifo_count2),
        .overflow     (overflow2),
        .overflow_clr (overflow_clr2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    // Sample the 16x line at ten points spaced one bit apart, first at 'first'.
    task automatic rx_frame(input int first, output logic [9:0] bits);
        for (int b = 0; b < 10; b++) begin
            goto(first + 16 * b);
            bits[b] = tx;
        end
    endtask

    initial begin
        int          e0;
        logic [9:0]  bits;
        logic [7:0]  exp_ch;
        logic [7:0]  q8;
        logic [7:0]  exp_q[$];

        reset         = 1'b1;
        char_in       = '0;
        overflow_clr  = 1'b0;
        char_in2      = '0;
        overflow_clr2 = 1'b0;

        // 1: reset state, then quiet line.
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        tick();
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_stable", {tx, busy, overflow, fifo_count}, {1'b1, 1'b0, 1'b0, 5'd0});
        end

        // 2: single 0x55 frame.
        e0 = cyc + 1;
        char_in = 9'h155;
        tick();
        char_in = '0;
        check("t2_count_e0", fifo_count, 1);
        check("t2_tx_e0", tx, 1);
        tick();
        check("t2_count_e1", fifo_count, 0);
        check("t2_busy_e1", busy, 1);
        check("t2_tx_e1", tx, 1);
        tick();
        check("t2_tx_e2", tx, 0);
        rx_frame(e0 + 10, bits);
        check("t2_frame", bits, {1'b1, 8'h55, 1'b0});
        goto(e0 + 160);
        check("t2_busy_e160", busy, 1);
        goto(e0 + 161);
        check("t2_busy_e161", busy, 0);
        check("t2_tx_e161", tx, 1);

        // 3: "ABC" back to back.
        e0 = cyc + 1;
        char_in = 9'h141;
        tick();
        check("t3_count_e0", fifo_count, 1);
        char_in = 9'h142;
        tick();
        check("t3_count_e1", fifo_count, 1);
        char_in = 9'h143;
        tick();
        check("t3_count_e2", fifo_count, 2);
        char_in = '0;
        rx_frame(e0 + 10, bits);
        check("t3_frame_a", bits, {1'b1, 8'h41, 1'b0});
        goto(e0 + 161);
        check("t3_stop_a_last", tx, 1);
        goto(e0 + 162);
        check("t3_start_b_first", tx, 0);
        rx_frame(e0 + 170, bits);
        check("t3_frame_b", bits, {1'b1, 8'h42, 1'b0});
        rx_frame(e0 + 330, bits);
        check("t3_frame_c", bits, {1'b1, 8'h43, 1'b0});
        goto(e0 + 482);
        check("t3_busy_end", busy, 0);

        // 4: 18 consecutive strobes: 1 in flight, 16 buffered, last one dropped.
        e0 = cyc + 1;
        for (int i = 0; i < 18; i++) begin
            char_in = {1'b1, 8'(i)};
            tick();
            if (i == 16) begin
                check("t4_full_count", fifo_count, 16);
                check("t4_full_ovf", overflow, 0);
            end
            if (i == 17) begin
                check("t4_drop_count", fifo_count, 16);
                check("t4_drop_ovf", overflow, 1);
            end
        end
        char_in = '0;
        // Start-bit centre is already past; sample the last cycle of each bit.
        for (int f = 0; f < 17; f++) begin
            rx_frame(e0 + 17 + 160 * f, bits);
            exp_ch = 8'(f);
            check("t4_frame", bits, {1'b1, exp_ch, 1'b0});
        end
        goto(e0 + 2722);
        check("t4_busy_end", busy, 0);
        check("t4_ovf_sticky", overflow, 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("t4_ovf_clr", overflow, 0);
        // Refill; 18th strobe sets overflow, 19th collides with a clear.
        for (int i = 0; i < 19; i++) begin
            char_in = {1'b1, 8'(i)};
            overflow_clr = (i == 18);
            tick();
            if (i == 17) check("t4_reovf", overflow, 1);
            if (i == 18) begin
                check("t4_set_beats_clr", overflow, 1);
                check("t4_set_count", fifo_count, 16);
            end
        end
        char_in = '0;
        overflow_clr = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t4_rst_count", fifo_count, 0);
        check("t4_rst_ovf", overflow, 0);
        tick();
        reset = 1'b0;

        // 5: reset mid-frame during data bit 3 of 0xA5 with 4 queued.
        e0 = cyc + 1;
        char_in = 9'h1A5;
        tick();
        for (int i = 0; i < 4; i++) begin
            char_in = {1'b1, 8'(8'h30 + i)};
            tick();
        end
        char_in = '0;
        check("t5_queued", fifo_count, 4);
        goto(e0 + 74);
        check("t5_bit3", tx, 0);
        #3;
        reset = 1'b1;
        #1;
        check("t5_async_tx", tx, 1);
        check("t5_async_count", fifo_count, 0);
        check("t5_async_busy", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            check("t5_quiet", {tx, busy, fifo_count}, {1'b1, 1'b0, 5'd0});
        end

        // 6: random stream through the 2-clock-per-bit instance.
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    int gap;
                    gap = $urandom_range(49, 1);
                    repeat (gap - 1) tick();
                    q8 = 8'($urandom);
                    char_in2 = {1'b1, q8};
                    exp_q.push_back(q8);
                    tick();
                    char_in2 = '0;
                end
            end
            begin
                for (int m = 0; m < 200; m++) begin
                    int w;
                    int s;
                    logic [9:0] rb;
                    w = 0;
                    while (tx2 !== 1'b0 && w < 1000) begin
                        tick();
                        w++;
                    end
                    if (w >= 1000) begin
                        check("t6_start_timeout", tx2, 0);
                        break;
                    end
                    s = cyc;
                    for (int b = 0; b < 10; b++) begin
                        goto(s + 2 * b + 1);
                        rb[b] = tx2;
                    end
                    check("t6_have_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        logic [7:0] ec;
                        ec = exp_q.pop_front();
                        check("t6_frame", rb, {1'b1, ec, 1'b0});
                    end
                end
            end
        join
        repeat (30) tick();
        check("t6_overflow", overflow2, 0);
        check("t6_drained", {busy2, fifo_count2}, 6'd0);
        check("t6_leftover", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
